// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl
//
// Reconfiguration and lock supervisor for an analogue PLL.
// - It drives the MDSEL and ODSEL0 divider selects and the PLL RESET line.
// - It waits for LOCK and retries a bounded number of times.
// - It declares lock only after LOCK has held for a stable window.
// A new request is accepted only while the controller is idle: either running
// (RUN) or given up (FAIL).
//
// Ports
//   clk         free-running reference clock (not PLL-derived)
//   resetn      asynchronous active-low reset
//   req         reconfiguration request, sampled only while ready=1
//   req_mdiv    requested feedback multiplier (valid when >= 2)
//   req_odiv0   requested CLKOUT0 divider (valid when != 0)
//   ready       high in RUN or FAIL
//   done        one-cycle pulse on entry to RUN
//   err         one-cycle pulse on a rejected request or on entry to FAIL
//   locked      high only in RUN
//   pll_lock    raw PLL LOCK, asynchronous to clk
//   pll_reset   active-high PLL RESET
//   pll_mdsel   PLL MDSEL
//   pll_odsel0  PLL ODSEL0
//
// Build option
//   PLL_LOSS_RECOVERY_EN  when defined, losing lock in RUN restarts the lock
//                         sequence with the current dividers. When undefined,
//                         losing lock in RUN enters FAIL and pulses err.

module pll_reconfig_ctrl #(
    parameter int unsigned INIT_MDIV     = 27,
    parameter int unsigned INIT_ODIV0    = 50,
    parameter int unsigned RESET_CYCLES  = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65535,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req,
    input  logic [6:0] req_mdiv,
    input  logic [6:0] req_odiv0,
    output logic       ready,
    output logic       done,
    output logic       err,
    output logic       locked,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [6:0] pll_mdsel,
    output logic [6:0] pll_odsel0
);

    localparam logic [2:0] ST_RST    = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_FAIL   = 3'd4;

    // Each counter only needs to reach its terminal value (limit - 1).
    localparam int unsigned RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int unsigned TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int unsigned SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int unsigned YW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;

    localparam logic [RW-1:0] RST_LAST    = RW'(RESET_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(LOCK_TIMEOUT - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [YW-1:0] RETRY_LAST  = YW'(MAX_RETRY - 1);

    logic          lock_s1_q, lock_sync_q;
    logic [2:0]    state_q, state_d;
    logic [RW-1:0] rst_cnt_q, rst_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [SW-1:0] settle_cnt_q, settle_cnt_d;
    logic [YW-1:0] retry_q, retry_d;
    logic [6:0]    mdsel_q, mdsel_d;
    logic [6:0]    odsel_q, odsel_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          pll_reset_q, pll_reset_d;
    logic          idle;
    logic          req_ok;

    assign idle   = (state_q == ST_RUN) || (state_q == ST_FAIL);
    assign req_ok = (req_mdiv >= 7'd2) && (req_odiv0 != 7'd0);

    // The PLL LOCK output is asynchronous to clk, so it is synchronised by two flops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_s1_q   <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            lock_s1_q   <= pll_lock;
            lock_sync_q <= lock_s1_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        rst_cnt_d    = '0;
        to_cnt_d     = to_cnt_q;
        settle_cnt_d = settle_cnt_q;
        retry_d      = retry_q;
        mdsel_d      = mdsel_q;
        odsel_d      = odsel_q;
        err_d        = 1'b0;

        case (state_q)
            ST_RST: begin
                to_cnt_d     = '0;
                settle_cnt_d = '0;
                if (rst_cnt_q >= RST_LAST) begin
                    state_d = ST_WAIT;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            ST_WAIT: begin
                settle_cnt_d = '0;
                if (lock_sync_q) begin
                    // The cycle that first sees lock counts towards the stable window.
                    state_d      = ST_SETTLE;
                    settle_cnt_d = SW'(1);
                end else if (to_cnt_q >= TO_LAST) begin
                    // retry_q counts RST re-entries, so retry_q + 1 attempts have been made.
                    if (retry_q < RETRY_LAST) begin
                        state_d = ST_RST;
                        retry_d = (retry_q == '1) ? retry_q : retry_q + 1'b1;
                    end else begin
                        state_d = ST_FAIL;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_SETTLE: begin
                // A lock drop returns to WAIT. The timeout budget keeps running from where it was.
                if (!lock_sync_q) begin
                    state_d      = ST_WAIT;
                    settle_cnt_d = '0;
                end else if (settle_cnt_q >= SETTLE_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    settle_cnt_d = (settle_cnt_q == '1) ? settle_cnt_q : settle_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                retry_d = '0;
                if (!lock_sync_q) begin
`ifdef PLL_LOSS_RECOVERY_EN
                    state_d = ST_RST;
`else
                    state_d = ST_FAIL;
`endif
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_RST;
            end
        endcase

        // An accepted request overrides the FSM. A rejected request only flags err.
        if (idle && req) begin
            if (req_ok) begin
                state_d   = ST_RST;
                rst_cnt_d = '0;
                retry_d   = '0;
                mdsel_d   = req_mdiv;
                odsel_d   = req_odiv0;
            end else begin
                err_d = 1'b1;
            end
        end

        if ((state_d == ST_FAIL) && (state_q != ST_FAIL)) begin
            err_d = 1'b1;
        end
        done_d      = (state_d == ST_RUN) && (state_q != ST_RUN);
        pll_reset_d = (state_d == ST_RST) || (state_d == ST_FAIL);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_RST;
            rst_cnt_q    <= '0;
            to_cnt_q     <= '0;
            settle_cnt_q <= '0;
            retry_q      <= '0;
            mdsel_q      <= 7'(INIT_MDIV);
            odsel_q      <= 7'(INIT_ODIV0);
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            pll_reset_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            to_cnt_q     <= to_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            retry_q      <= retry_d;
            mdsel_q      <= mdsel_d;
            odsel_q      <= odsel_d;
            done_q       <= done_d;
            err_q        <= err_d;
            pll_reset_q  <= pll_reset_d;
        end
    end

    assign ready      = idle;
    assign locked     = (state_q == ST_RUN);
    assign done       = done_q;
    assign err        = err_q;
    assign pll_reset  = pll_reset_q;
    assign pll_mdsel  = mdsel_q;
    assign pll_odsel0 = odsel_q;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Self-checking bench for pll_reconfig_ctrl. Lock timeout is shortened to keep run time small.
module tb_pll_reconfig_ctrl;

    localparam int unsigned T_RESET   = 16;
    localparam int unsigned T_TIMEOUT = 400;
    localparam int unsigned T_STABLE  = 1024;
    localparam int unsigned T_RETRY   = 3;
    localparam int          LOCK_LAT  = T_STABLE + 2;
    localparam int          BOUND     = 5000;

    logic       clk = 1'b0;
    logic       resetn;
    logic       req;
    logic [6:0] req_mdiv;
    logic [6:0] req_odiv0;
    logic       ready, done, err, locked;
    logic       pll_lock;
    logic       pll_reset;
    logic [6:0] pll_mdsel, pll_odsel0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit         is_err;
        logic [6:0] m;
        logic [6:0] o;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    pll_reconfig_ctrl #(
        .INIT_MDIV    (27),
        .INIT_ODIV0   (50),
        .RESET_CYCLES (T_RESET),
        .LOCK_TIMEOUT (T_TIMEOUT),
        .STABLE_CYCLES(T_STABLE),
        .MAX_RETRY    (T_RETRY)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req       (req),
        .req_mdiv  (req_mdiv),
        .req_odiv0 (req_odiv0),
        .ready     (ready),
        .done      (done),
        .err       (err),
        .locked    (locked),
        .pll_lock  (pll_lock),
        .pll_reset (pll_reset),
        .pll_mdsel (pll_mdsel),
        .pll_odsel0(pll_odsel0)
    );

    // Stimulus helpers: drive a request for one edge; return at the following negedge.
    task automatic issue_req(input logic [6:0] m, input logic [6:0] o);
        req = 1'b1; req_mdiv = m; req_odiv0 = o;
        @(posedge clk); #1 req = 1'b0;
        @(negedge clk);
    endtask

    // Called at a negedge; counts negedges with pll_reset high.
    task automatic wait_reset_fall(output int n);
        n = 0;
        while (pll_reset === 1'b1 && n < BOUND) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_reset_rise(output int n);
        n = 0;
        while (pll_reset === 1'b0 && n < BOUND) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Called just after the edge that raised pll_lock; counts edges until done is seen.
    task automatic count_to_done(output int n, output bit ready_bad);
        n = 0; ready_bad = 1'b0;
        while (n < BOUND) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done === 1'b1) break;
            if (ready !== 1'b0) ready_bad = 1'b1;
        end
    endtask

    task automatic relock(input int delay, input string tag);
        int n; bit rbad; exp_t e;
        repeat (delay) @(posedge clk);
        #1 pll_lock = 1'b1;
        count_to_done(n, rbad);
        total++;
        if (n !== LOCK_LAT) begin
            bad++; $display("FAIL %s lock_to_done: got %0d cycles, want %0d", tag, n, LOCK_LAT);
        end
        total++;
        if (rbad) begin
            bad++; $display("FAIL %s ready_before_done: got 1, want 0", tag);
        end
        total++;
        if (locked !== 1'b1 || ready !== 1'b1) begin
            bad++; $display("FAIL %s run_flags: locked=%b ready=%b, want 1 1", tag, locked, ready);
        end
        total++;
        if (sb.size() == 0) begin
            bad++; $display("FAIL %s scoreboard: done seen with empty queue, want queued entry", tag);
        end else begin
            e = sb.pop_front();
            if (e.is_err || pll_mdsel !== e.m || pll_odsel0 !== e.o) begin
                bad++;
                $display("FAIL %s dividers: got done %0d/%0d, want err=%0d %0d/%0d",
                         tag, pll_mdsel, pll_odsel0, e.is_err, e.m, e.o);
            end
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++; $display("FAIL %s done_pulse_width: got done=%b next cycle, want 0", tag, done);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; req = 1'b0; req_mdiv = '0; req_odiv0 = '0; pll_lock = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({pll_reset, done, err, locked, ready} !== 5'b10000) begin
            bad++;
            $display("FAIL reset_flags: got rst/done/err/locked/ready=%b, want 10000",
                     {pll_reset, done, err, locked, ready});
        end
        total++;
        if (pll_mdsel !== 7'd27) begin
            bad++; $display("FAIL reset_mdsel: got %0d, want 27", pll_mdsel);
        end
        total++;
        if (pll_odsel0 !== 7'd50) begin
            bad++; $display("FAIL reset_odsel0: got %0d, want 50", pll_odsel0);
        end
    endtask

    task automatic test_bringup(input string tag);
        int n;
        sb.push_back('{1'b0, 7'd27, 7'd50});
        @(posedge clk); #1 resetn = 1'b1;
        @(negedge clk);
        wait_reset_fall(n);
        total++;
        if (n !== T_RESET) begin
            bad++; $display("FAIL %s reset_width: got %0d, want %0d", tag, n, T_RESET);
        end
        relock(100, tag);
    endtask

    task automatic test_reject();
        logic [6:0] ms[2] = '{7'd1, 7'd5};
        logic [6:0] os[2] = '{7'd40, 7'd0};
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{1'b1, 7'd0, 7'd0});
            issue_req(ms[i], os[i]);
            total++;
            if (err !== 1'b1) begin
                bad++; $display("FAIL reject%0d err: got %b, want 1", i, err);
            end
            if (sb.size() != 0 && err === 1'b1) begin
                e = sb.pop_front();
                total++;
                if (!e.is_err) begin
                    bad++; $display("FAIL reject%0d scoreboard: got err, want done", i);
                end
            end
            total++;
            if ({locked, ready, pll_reset} !== 3'b110 || pll_mdsel !== 7'd27 || pll_odsel0 !== 7'd50)
            begin
                bad++;
                $display("FAIL reject%0d state: got lk/rdy/rst=%b div=%0d/%0d, want 110 27/50",
                         i, {locked, ready, pll_reset}, pll_mdsel, pll_odsel0);
            end
            @(negedge clk);
            total++;
            if (err !== 1'b0) begin
                bad++; $display("FAIL reject%0d err_pulse_width: got %b, want 0", i, err);
            end
        end
        if (sb.size() != 0) void'(sb.pop_front());
    endtask

    task automatic test_reconfig();
        int n;
        sb.push_back('{1'b0, 7'd30, 7'd40});
        issue_req(7'd30, 7'd40);
        pll_lock = 1'b0;
        total++;
        if (pll_mdsel !== 7'd30 || pll_odsel0 !== 7'd40) begin
            bad++; $display("FAIL reconfig_div: got %0d/%0d, want 30/40", pll_mdsel, pll_odsel0);
        end
        total++;
        if (pll_reset !== 1'b1 || ready !== 1'b0 || locked !== 1'b0) begin
            bad++;
            $display("FAIL reconfig_flags: got rst=%b rdy=%b lk=%b, want 1 0 0",
                     pll_reset, ready, locked);
        end
        wait_reset_fall(n);
        total++;
        if (n !== T_RESET) begin
            bad++; $display("FAIL reconfig_reset_width: got %0d, want %0d", n, T_RESET);
        end
        relock(20, "reconfig");
    endtask

    task automatic test_wait_req();
        int n; bit bad_flag;
        sb.push_back('{1'b0, 7'd2, 7'd1});
        issue_req(7'd2, 7'd1);
        pll_lock = 1'b0;
        wait_reset_fall(n);
        bad_flag = 1'b0;
        req = 1'b1; req_mdiv = 7'd99; req_odiv0 = 7'd99;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (err !== 1'b0 || pll_reset !== 1'b0 || pll_mdsel !== 7'd2 || pll_odsel0 !== 7'd1)
                bad_flag = 1'b1;
        end
        req = 1'b0;
        total++;
        if (bad_flag) begin
            bad++;
            $display("FAIL wait_req_ignored: got err=%b rst=%b div=%0d/%0d, want 0 0 2/1",
                     err, pll_reset, pll_mdsel, pll_odsel0);
        end
        relock(30, "boundary");
    endtask

    task automatic test_glitch();
        int n; bit rbad, early; exp_t e;
        sb.push_back('{1'b0, 7'd30, 7'd40});
        issue_req(7'd30, 7'd40);
        pll_lock = 1'b0;
        wait_reset_fall(n);
        repeat (10) @(posedge clk);
        #1 pll_lock = 1'b1;
        early = 1'b0;
        repeat (500) begin
            @(negedge clk);
            if (done !== 1'b0) early = 1'b1;
        end
        @(posedge clk); #1 pll_lock = 1'b0;
        @(posedge clk); #1 pll_lock = 1'b1;
        count_to_done(n, rbad);
        total++;
        if (early) begin
            bad++; $display("FAIL glitch_early_done: got done before glitch, want none");
        end
        total++;
        if (n !== LOCK_LAT) begin
            bad++; $display("FAIL glitch_relock: got %0d cycles, want %0d", n, LOCK_LAT);
        end
        total++;
        if (sb.size() == 0) begin
            bad++; $display("FAIL glitch_scoreboard: got empty queue, want entry");
        end else begin
            e = sb.pop_front();
            if (e.is_err || pll_mdsel !== e.m || pll_odsel0 !== e.o) begin
                bad++; $display("FAIL glitch_div: got %0d/%0d, want %0d/%0d",
                                pll_mdsel, pll_odsel0, e.m, e.o);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_lock_loss();
        int n; exp_t e;
        pll_lock = 1'b0;
        n = 0;
`ifdef PLL_LOSS_RECOVERY_EN
        while (n < 10) begin
            @(negedge clk); n++;
            if (pll_reset === 1'b1) break;
        end
        total++;
        if (n !== 3 || locked !== 1'b0 || ready !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL loss_recover: got n=%0d lk=%b rdy=%b err=%b, want 3 0 0 0",
                     n, locked, ready, err);
        end
        sb.push_back('{1'b0, 7'd30, 7'd40});
        wait_reset_fall(n);
        relock(25, "loss_relock");
`else
        sb.push_back('{1'b1, 7'd0, 7'd0});
        while (n < 10) begin
            @(negedge clk); n++;
            if (err === 1'b1) break;
        end
        total++;
        if (n !== 3) begin
            bad++; $display("FAIL loss_err_latency: got %0d, want 3", n);
        end
        total++;
        if (pll_reset !== 1'b1 || locked !== 1'b0 || ready !== 1'b1) begin
            bad++;
            $display("FAIL loss_fail_state: got rst=%b lk=%b rdy=%b, want 1 0 1",
                     pll_reset, locked, ready);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            total++;
            if (!e.is_err) begin
                bad++; $display("FAIL loss_scoreboard: got err, want done");
            end
        end
`endif
    endtask

    task automatic test_timeout();
        int n; bit hold_bad; exp_t e;
        pll_lock = 1'b0;
        sb.push_back('{1'b1, 7'd0, 7'd0});
        issue_req(7'd40, 7'd20);
        for (int p = 0; p < 3; p++) begin
            wait_reset_fall(n);
            total++;
            if (n !== T_RESET) begin
                bad++; $display("FAIL timeout_pulse%0d: got width %0d, want %0d", p, n, T_RESET);
            end
            wait_reset_rise(n);
            total++;
            if (n !== T_TIMEOUT) begin
                bad++; $display("FAIL timeout_gap%0d: got %0d, want %0d", p, n, T_TIMEOUT);
            end
            if (p < 2) begin
                total++;
                if (ready !== 1'b0 || err !== 1'b0) begin
                    bad++; $display("FAIL timeout_retry%0d: got rdy=%b err=%b, want 0 0",
                                    p, ready, err);
                end
            end
        end
        total++;
        if (err !== 1'b1 || ready !== 1'b1 || locked !== 1'b0) begin
            bad++; $display("FAIL timeout_fail: got err=%b rdy=%b lk=%b, want 1 1 0",
                            err, ready, locked);
        end
        if (sb.size() != 0) void'(sb.pop_front());
        hold_bad = 1'b0;
        repeat (600) begin
            @(negedge clk);
            if (pll_reset !== 1'b1 || err !== 1'b0 || ready !== 1'b1) hold_bad = 1'b1;
        end
        total++;
        if (hold_bad) begin
            bad++; $display("FAIL fail_hold: got rst=%b err=%b rdy=%b, want 1 0 1",
                            pll_reset, err, ready);
        end
        sb.push_back('{1'b1, 7'd0, 7'd0});
        issue_req(7'd0, 7'd10);
        total++;
        if (err !== 1'b1 || pll_reset !== 1'b1 || ready !== 1'b1 || pll_mdsel !== 7'd40) begin
            bad++;
            $display("FAIL fail_reject: got err=%b rst=%b rdy=%b md=%0d, want 1 1 1 40",
                     err, pll_reset, ready, pll_mdsel);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            total++;
            if (!e.is_err) begin
                bad++; $display("FAIL fail_reject_scoreboard: got err, want done");
            end
        end
    endtask

    task automatic test_recover();
        int n;
        sb.push_back('{1'b0, 7'd27, 7'd50});
        issue_req(7'd27, 7'd50);
        wait_reset_fall(n);
        total++;
        if (n !== T_RESET) begin
            bad++; $display("FAIL recover_reset_width: got %0d, want %0d", n, T_RESET);
        end
        relock(50, "recover");
    endtask

    task automatic test_midseq_reset();
        int n;
        issue_req(7'd30, 7'd40);
        pll_lock = 1'b0;
        wait_reset_fall(n);
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        #1;
        total++;
        if (pll_reset !== 1'b1 || ready !== 1'b0 || pll_mdsel !== 7'd27 || pll_odsel0 !== 7'd50)
        begin
            bad++;
            $display("FAIL midseq_reset: got rst=%b rdy=%b div=%0d/%0d, want 1 0 27/50",
                     pll_reset, ready, pll_mdsel, pll_odsel0);
        end
        repeat (2) @(negedge clk);
        test_bringup("rebringup");
    endtask

    initial begin
        test_reset();
        test_bringup("bringup");
        test_reject();
        test_reconfig();
        test_wait_req();
        test_glitch();
        test_lock_loss();
        test_timeout();
        test_recover();
        test_midseq_reset();
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL scoreboard_drain: got %0d left, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pll_reconfig_ctrl.md
PLL_RECONFIG_CTRL -- requirements
Module: pll_reconfig_ctrl

Interface
REQ-001 SHALL have parameter INIT_MDIV, default 27, MDSEL value driven from reset.
REQ-002 SHALL have parameter INIT_ODIV0, default 50, ODSEL0 value driven from reset.
REQ-003 SHALL have parameter RESET_CYCLES, default 16, PLL reset pulse width in clk cycles.
REQ-004 SHALL have parameter LOCK_TIMEOUT, default 65535, max clk cycles waiting for lock per attempt.
REQ-005 SHALL have parameter STABLE_CYCLES, default 1024, cycles lock must hold before declaring locked.
REQ-006 SHALL have parameter MAX_RETRY, default 3, lock attempts per request before failure.
REQ-007 SHALL have port clk, input, 1, free-running PLL reference clock (50 MHz), not PLL-derived.
REQ-008 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port req, input, 1, reconfiguration request, sampled only when ready=1.
REQ-010 SHALL have port req_mdiv, input, 7, requested feedback multiplier.
REQ-011 SHALL have port req_odiv0, input, 7, requested CLKOUT0 divider.
REQ-012 SHALL have port ready, output, 1, high in RUN or FAIL only.
REQ-013 SHALL have port done, output, 1, one-cycle pulse on entry to RUN.
REQ-014 SHALL have port err, output, 1, one-cycle pulse on rejected request or entry to FAIL.
REQ-015 SHALL have port locked, output, 1, high only in RUN.
REQ-016 SHALL have port pll_lock, input, 1, raw PLL LOCK, asynchronous to clk.
REQ-017 SHALL have port pll_reset, output, 1, active-high PLL RESET.
REQ-018 SHALL have port pll_mdsel, output, 7, PLL MDSEL.
REQ-019 SHALL have port pll_odsel0, output, 7, PLL ODSEL0.

Function
REQ-020 SHALL synchronise pll_lock through two flops; all lock decisions use the synchronised value.
REQ-021 SHALL implement states RST, WAIT, SETTLE, RUN, FAIL.
REQ-022 RST: pll_reset=1 for exactly RESET_CYCLES cycles, then WAIT; retry counter incremented on each RST entry.
REQ-023 WAIT: sync lock=1 -> SETTLE; timeout counter reaching LOCK_TIMEOUT -> RST if retries < MAX_RETRY, else FAIL.
REQ-024 SETTLE: lock held STABLE_CYCLES consecutive cycles -> RUN; lock drop -> WAIT, settle counter cleared, timeout counter not cleared.
REQ-025 RUN: locked=1, ready=1; retry counter cleared on entry.
REQ-026 Accepted req (ready=1, req=1): latch req_mdiv/req_odiv0 onto pll_mdsel/pll_odsel0 next edge, retry counter cleared, go RST.
REQ-027 Request with req_mdiv<2 or req_odiv0=0 SHALL be rejected: err pulse, no state or divider change.
REQ-028 req while ready=0 SHALL be ignored without err.
REQ-029 pll_mdsel/pll_odsel0 SHALL change only on an accepted request, never during RST/WAIT/SETTLE.
REQ-030 FAIL: pll_reset=1 held, locked=0, ready=1; only a valid req leaves FAIL.
REQ-031 All counters SHALL saturate, never wrap.

Reset
REQ-032 During resetn=0: state RST with counters zero, pll_reset=1, pll_mdsel=INIT_MDIV, pll_odsel0=INIT_ODIV0, done=err=locked=ready=0.
REQ-033 After resetn release SHALL run full RST->WAIT->SETTLE->RUN sequence with init dividers; reset mid-sequence restarts from RST.

Configuration
REQ-034 Macro PLL_LOSS_RECOVERY_EN defined: sync lock=0 in RUN -> RST (locked drops next cycle, retry counter cleared, dividers kept).
REQ-035 Macro PLL_LOSS_RECOVERY_EN undefined: sync lock=0 in RUN -> FAIL with err pulse.

Verification
REQ-036 Release resetn, pll_lock rises 100 cycles after pll_reset falls -> pll_reset high 16 cycles, done pulse and locked=1 exactly 1024+2 cycles after lock rise, mdsel=27, odsel0=50.
REQ-037 In RUN, req mdiv=30 odiv0=40 -> outputs 30/40 next cycle, pll_reset 16 cycles, ready=0 until done.
REQ-038 pll_lock never rises -> 3 reset pulses each 65535 cycles apart, FAIL, err single pulse, pll_reset stays high.
REQ-039 Lock glitch low 1 cycle at SETTLE count 500 -> back to WAIT, done only after a further 1024 stable cycles.
REQ-040 req mdiv=1 in RUN -> err pulse, state RUN, dividers unchanged; req during WAIT -> ignored.
REQ-041 Lock drop in RUN -> with PLL_LOSS_RECOVERY_EN: RST and re-lock; without: FAIL plus err pulse.
